// File: rtl/tl_pkg.sv
// Shared types and helpers for the lamp-side traffic-light monitor blocks.
// Latency: none (types, constants and a pure function only).
// Backpressure: none.
package tl_pkg;

  // Displayed phase; the numeric values are what the phase output reports.
  typedef enum logic [1:0] {
    PH_AG = 2'd0,
    PH_AY = 2'd1,
    PH_BG = 2'd2,
    PH_BY = 2'd3
  } phase_e;

  typedef enum logic [1:0] {
    M_INIT  = 2'd0,
    M_RUN   = 2'd1,
    M_FAULT = 2'd2
  } mstate_e;

  localparam logic [2:0] FC_NONE     = 3'd0;
  localparam logic [2:0] FC_ENCODING = 3'd1;
  localparam logic [2:0] FC_CONFLICT = 3'd2;
  localparam logic [2:0] FC_ILLEGAL  = 3'd3;
  localparam logic [2:0] FC_Y_SHORT  = 3'd4;
  localparam logic [2:0] FC_G_SHORT  = 3'd5;

  // The only phase a well-behaved controller may move to from ph.
  function automatic phase_e next_phase(input phase_e ph);
    next_phase = PH_AG;
    case (ph)
      PH_AG: next_phase = PH_AY;
      PH_AY: next_phase = PH_BG;
      PH_BG: next_phase = PH_BY;
      PH_BY: next_phase = PH_AG;
    endcase
  endfunction

endpackage

// File: rtl/tl_conflict_monitor_if.sv
// Lamp drive lines plus monitor status, bundled between controller side and monitor.
// Latency: none (wires only).
// Backpressure: none; lamps are sampled every cycle. Optional fault_count under TL_MON_FAULT_COUNT_EN.
interface tl_conflict_monitor_if;
  logic       Ga, Ya, Ra;
  logic       Gb, Yb, Rb;
  logic       clr_fault;
  logic [1:0] phase;
  logic       phase_valid;
  logic       fault;
  logic [2:0] fault_code;
  logic       flash;
`ifdef TL_MON_FAULT_COUNT_EN
  logic [7:0] fault_count;
`endif

  // Lamp/controller side.
  modport master (
    output Ga, Ya, Ra, Gb, Yb, Rb, clr_fault,
    input  phase, phase_valid, fault, fault_code, flash
`ifdef TL_MON_FAULT_COUNT_EN
    , input fault_count
`endif
  );

  // Monitor side.
  modport slave (
    input  Ga, Ya, Ra, Gb, Yb, Rb, clr_fault,
    output phase, phase_valid, fault, fault_code, flash
`ifdef TL_MON_FAULT_COUNT_EN
    , output fault_count
`endif
  );
endinterface

// File: rtl/tl_lamp_decode.sv
// Combinational decode of the six lamp lines into phase / legal / conflict / all_off.
// Latency: 0 cycles.
// Backpressure: none.
module tl_lamp_decode
  import tl_pkg::*;
(
  input  logic [5:0] lamps_i,     // {Ga, Ya, Ra, Gb, Yb, Rb}
  output phase_e     phase_o,
  output logic       legal_o,
  output logic       conflict_o,
  output logic       all_off_o
);

  logic ga, ya, ra, gb, yb, rb;
  assign {ga, ya, ra, gb, yb, rb} = lamps_i;

  // Only four exact patterns are legal; both-red and every other mix are encoding faults.
  always_comb begin
    phase_o = PH_AG;
    legal_o = 1'b0;
    case (lamps_i)
      6'b100_001: begin phase_o = PH_AG; legal_o = 1'b1; end
      6'b010_001: begin phase_o = PH_AY; legal_o = 1'b1; end
      6'b001_100: begin phase_o = PH_BG; legal_o = 1'b1; end
      6'b001_010: begin phase_o = PH_BY; legal_o = 1'b1; end
      default:    ;
    endcase
  end

  // With red off, any lit lamp on a side is green or yellow, i.e. traffic released.
  assign conflict_o = !ra && !rb && (ga || ya) && (gb || yb);
  assign all_off_o  = (lamps_i == 6'b000_000);

endmodule

// File: rtl/tl_conflict_monitor.sv
// Lamp-side safety monitor: checks encoding, conflicts, phase order and dwell; latches a fault.
// Latency: lamps registered once, status updates on the 2nd rising edge after a pattern appears.
// Backpressure: none; faults hold until clr_fault. Optional fault_count under TL_MON_FAULT_COUNT_EN.
module tl_conflict_monitor
  import tl_pkg::*;
#(
  parameter int MIN_GREEN  = 4,
  parameter int MIN_YELLOW = 2,
  parameter int FLASH_DIV  = 8,
  parameter int CNT_W      = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  tl_conflict_monitor_if.slave bus
);

  logic [5:0]       s_lamps_q;
  phase_e           dec_phase;
  logic             dec_legal, dec_conflict, dec_all_off;

  logic [1:0]       state_q, state_d;
  phase_e           phase_q, phase_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;
  logic             first_q, first_d;
  logic             fault_q, fault_d;
  logic [2:0]       code_q, code_d;
  logic             flash_q, flash_d;
  logic             raise;
  logic [2:0]       raise_code;

  // Single input register; every check looks only at this sampled copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s_lamps_q <= '0;
    else        s_lamps_q <= {bus.Ga, bus.Ya, bus.Ra, bus.Gb, bus.Yb, bus.Rb};
  end

  tl_lamp_decode u_decode (
    .lamps_i    (s_lamps_q),
    .phase_o    (dec_phase),
    .legal_o    (dec_legal),
    .conflict_o (dec_conflict),
    .all_off_o  (dec_all_off)
  );

  // Next-state: checks are arranged so only the highest-priority code can be raised.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    dwell_d    = dwell_q;
    fcnt_d     = fcnt_q;
    first_d    = first_q;
    fault_d    = fault_q;
    code_d     = code_q;
    flash_d    = flash_q;
    raise      = 1'b0;
    raise_code = FC_NONE;
    case (state_q)
      M_INIT: begin
        if (dec_conflict) begin
          raise = 1'b1; raise_code = FC_CONFLICT;
        end else if (!dec_all_off && dec_legal) begin
          // First phase after start-up or clear is accepted without a dwell check.
          state_d = M_RUN;
          phase_d = dec_phase;
          dwell_d = CNT_W'(1);
          first_d = 1'b1;
        end
      end
      M_RUN: begin
        if (dec_conflict) begin
          raise = 1'b1; raise_code = FC_CONFLICT;
        end else if (!dec_legal) begin
          raise = 1'b1; raise_code = FC_ENCODING;
        end else if (dec_phase == phase_q) begin
          if (dwell_q != '1) dwell_d = dwell_q + CNT_W'(1);
        end else if (dec_phase == next_phase(phase_q)) begin
          if (!first_q && (phase_q == PH_AY || phase_q == PH_BY) &&
              dwell_q < CNT_W'(MIN_YELLOW)) begin
            raise = 1'b1; raise_code = FC_Y_SHORT;
          end else if (!first_q && (phase_q == PH_AG || phase_q == PH_BG) &&
                       dwell_q < CNT_W'(MIN_GREEN)) begin
            raise = 1'b1; raise_code = FC_G_SHORT;
          end else begin
            phase_d = dec_phase;
            dwell_d = CNT_W'(1);
            first_d = 1'b0;
          end
        end else begin
          raise = 1'b1; raise_code = FC_ILLEGAL;
        end
      end
      M_FAULT: begin
        if (bus.clr_fault) begin
          state_d = M_INIT;
          phase_d = PH_AG;
          dwell_d = '0;
          fcnt_d  = '0;
          first_d = 1'b0;
          fault_d = 1'b0;
          code_d  = FC_NONE;
          flash_d = 1'b0;
        end else if (fcnt_q >= CNT_W'(FLASH_DIV)) begin
          flash_d = ~flash_q;
          fcnt_d  = CNT_W'(1);
        end else begin
          fcnt_d  = fcnt_q + CNT_W'(1);
        end
      end
      default: state_d = M_INIT;
    endcase
    // Entry cycle counts as the first cycle of the lit flash half-period.
    if (raise) begin
      state_d = M_FAULT;
      fault_d = 1'b1;
      code_d  = raise_code;
      flash_d = 1'b1;
      fcnt_d  = CNT_W'(1);
    end
  end

  // Monitor state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= M_INIT;
      phase_q <= PH_AG;
      dwell_q <= '0;
      fcnt_q  <= '0;
      first_q <= 1'b0;
      fault_q <= 1'b0;
      code_q  <= FC_NONE;
      flash_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      dwell_q <= dwell_d;
      fcnt_q  <= fcnt_d;
      first_q <= first_d;
      fault_q <= fault_d;
      code_q  <= code_d;
      flash_q <= flash_d;
    end
  end

  assign bus.phase       = phase_q;
  assign bus.phase_valid = (state_q == M_RUN);
  assign bus.fault       = fault_q;
  assign bus.fault_code  = code_q;
  assign bus.flash       = flash_q;

`ifdef TL_MON_FAULT_COUNT_EN
  logic [7:0] fault_count_q;

  // Lifetime count of fault entries; survives clr_fault, only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             fault_count_q <= '0;
    else if (raise && fault_count_q != '1)  fault_count_q <= fault_count_q + 8'd1;
  end

  assign bus.fault_count = fault_count_q;
`endif

endmodule

// File: tb/tb_tl_conflict_monitor.sv
// Directed bench for tl_conflict_monitor: normal cycling, each fault code, flash, clear, reset.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: none.
module tb_tl_conflict_monitor;
  import tl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tl_conflict_monitor_if bus ();

  tl_conflict_monitor #(
    .MIN_GREEN(4), .MIN_YELLOW(2), .FLASH_DIV(8), .CNT_W(8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Lamp patterns {Ga,Ya,Ra,Gb,Yb,Rb}.
  localparam logic [5:0] L_OFF = 6'b000_000;
  localparam logic [5:0] L_AG  = 6'b100_001;
  localparam logic [5:0] L_AY  = 6'b010_001;
  localparam logic [5:0] L_BG  = 6'b001_100;
  localparam logic [5:0] L_BY  = 6'b001_010;
  localparam logic [5:0] L_RR  = 6'b001_001;
  localparam logic [5:0] L_GG  = 6'b100_100;

  // Status {phase_valid, phase, fault, fault_code, flash}; phase is only meaningful while valid.
  function automatic logic [7:0] stat();
    return {bus.phase_valid, (bus.phase_valid ? bus.phase : 2'd0),
            bus.fault, bus.fault_code, bus.flash};
  endfunction

  // Same status with phase unmasked, for points where every output must be zero.
  function automatic logic [7:0] raw();
    return {bus.phase_valid, bus.phase, bus.fault, bus.fault_code, bus.flash};
  endfunction

  function automatic logic [7:0] st(input logic pv, input logic [1:0] ph, input logic f,
                                    input logic [2:0] c, input logic fl);
    return {pv, ph, f, c, fl};
  endfunction

  task automatic set_lamps(input logic [5:0] l);
    {bus.Ga, bus.Ya, bus.Ra, bus.Gb, bus.Yb, bus.Rb} = l;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] l, input int n);
    set_lamps(l);
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.clr_fault = 1'b0;
    set_lamps(L_OFF);
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  task automatic clear_fault(input string name);
    set_lamps(L_OFF);
    bus.clr_fault = 1'b1;
    step();
    bus.clr_fault = 1'b0;
    n_chk++;
    if (raw() !== 8'h00) $display("FAIL %s_clear got %b want %b", name, raw(), 8'h00);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.clr_fault = 1'b0;
    set_lamps(L_AG);
    #2;
    n_chk++;
    if (raw() !== 8'h00) $display("FAIL reset_outputs got %b want %b", raw(), 8'h00);
    else n_pass++;
    repeat (2) step();
    n_chk++;
    if (raw() !== 8'h00) $display("FAIL reset_held got %b want %b", raw(), 8'h00);
    else n_pass++;
    set_lamps(L_OFF);
    rst_n = 1'b1;
  endtask

  task automatic test_normal();
    logic [5:0] pat [4] = '{L_AG, L_AY, L_BG, L_BY};
    int         dur [4] = '{5, 2, 4, 2};
    int         prev = -1;
    logic [7:0] exp;
    for (int r = 0; r < 3; r++) begin
      for (int p = 0; p < 4; p++) begin
        for (int c = 0; c < dur[p]; c++) begin
          set_lamps(pat[p]);
          step();
          exp = (prev < 0) ? 8'h00 : st(1'b1, 2'(prev), 1'b0, 3'd0, 1'b0);
          n_chk++;
          if (stat() !== exp)
            $display("FAIL normal_r%0d_p%0d_c%0d got %b want %b", r, p, c, stat(), exp);
          else n_pass++;
          prev = p;
        end
      end
    end
  endtask

  task automatic test_conflict();
    logic [7:0] exp;
    set_lamps(L_GG);
    step();
    n_chk++;
    if (stat() !== st(1'b1, 2'd3, 1'b0, 3'd0, 1'b0))
      $display("FAIL conflict_lag got %b want %b", stat(), st(1'b1, 2'd3, 1'b0, 3'd0, 1'b0));
    else n_pass++;
    step();
    n_chk++;
    if (stat() !== st(1'b0, 2'd0, 1'b1, 3'd2, 1'b1))
      $display("FAIL conflict_code got %b want %b", stat(), st(1'b0, 2'd0, 1'b1, 3'd2, 1'b1));
    else n_pass++;
    for (int i = 1; i <= 16; i++) begin
      step();
      exp = st(1'b0, 2'd0, 1'b1, 3'd2, (i < 8 || i == 16) ? 1'b1 : 1'b0);
      n_chk++;
      if (stat() !== exp) $display("FAIL conflict_flash_%0d got %b want %b", i, stat(), exp);
      else n_pass++;
    end
    clear_fault("conflict");
    step();
    n_chk++;
    if (raw() !== 8'h00) $display("FAIL conflict_init_idle got %b want %b", raw(), 8'h00);
    else n_pass++;
  endtask

  task automatic test_short_yellow();
    drive(L_AG, 5);
    drive(L_AY, 1);
    set_lamps(L_BG);
    step();
    n_chk++;
    if (stat() !== st(1'b1, 2'd1, 1'b0, 3'd0, 1'b0))
      $display("FAIL short_y_lag got %b want %b", stat(), st(1'b1, 2'd1, 1'b0, 3'd0, 1'b0));
    else n_pass++;
    step();
    n_chk++;
    if (stat() !== st(1'b0, 2'd0, 1'b1, 3'd4, 1'b1))
      $display("FAIL short_y_code got %b want %b", stat(), st(1'b0, 2'd0, 1'b1, 3'd4, 1'b1));
    else n_pass++;
    clear_fault("short_y");
  endtask

  task automatic test_short_green();
    drive(L_AG, 5);
    drive(L_AY, 2);
    drive(L_BG, 4);
    drive(L_BY, 2);
    drive(L_AG, 3);
    set_lamps(L_AY);
    step();
    n_chk++;
    if (stat() !== st(1'b1, 2'd0, 1'b0, 3'd0, 1'b0))
      $display("FAIL short_g_lag got %b want %b", stat(), st(1'b1, 2'd0, 1'b0, 3'd0, 1'b0));
    else n_pass++;
    step();
    n_chk++;
    if (stat() !== st(1'b0, 2'd0, 1'b1, 3'd5, 1'b1))
      $display("FAIL short_g_code got %b want %b", stat(), st(1'b0, 2'd0, 1'b1, 3'd5, 1'b1));
    else n_pass++;
    clear_fault("short_g");
  endtask

  task automatic test_illegal();
    drive(L_AG, 5);
    set_lamps(L_BG);
    step();
    n_chk++;
    if (stat() !== st(1'b1, 2'd0, 1'b0, 3'd0, 1'b0))
      $display("FAIL illegal_lag got %b want %b", stat(), st(1'b1, 2'd0, 1'b0, 3'd0, 1'b0));
    else n_pass++;
    step();
    n_chk++;
    if (stat() !== st(1'b0, 2'd0, 1'b1, 3'd3, 1'b1))
      $display("FAIL illegal_code got %b want %b", stat(), st(1'b0, 2'd0, 1'b1, 3'd3, 1'b1));
    else n_pass++;
    drive(L_GG, 3);
    n_chk++;
    if (stat() !== st(1'b0, 2'd0, 1'b1, 3'd3, 1'b1))
      $display("FAIL illegal_held got %b want %b", stat(), st(1'b0, 2'd0, 1'b1, 3'd3, 1'b1));
    else n_pass++;
    clear_fault("illegal");
    drive(L_AG, 2);
    n_chk++;
    if (stat() !== st(1'b1, 2'd0, 1'b0, 3'd0, 1'b0))
      $display("FAIL illegal_recover got %b want %b", stat(), st(1'b1, 2'd0, 1'b0, 3'd0, 1'b0));
    else n_pass++;
    bus.clr_fault = 1'b1;
    step();
    bus.clr_fault = 1'b0;
    n_chk++;
    if (stat() !== st(1'b1, 2'd0, 1'b0, 3'd0, 1'b0))
      $display("FAIL clr_in_run got %b want %b", stat(), st(1'b1, 2'd0, 1'b0, 3'd0, 1'b0));
    else n_pass++;
  endtask

  task automatic test_encoding();
    // Continues in RUN showing AG.
    set_lamps(L_RR);
    step();
    step();
    n_chk++;
    if (stat() !== st(1'b0, 2'd0, 1'b1, 3'd1, 1'b1))
      $display("FAIL both_red_run got %b want %b", stat(), st(1'b0, 2'd0, 1'b1, 3'd1, 1'b1));
    else n_pass++;
    clear_fault("both_red");
    drive(L_RR, 3);
    n_chk++;
    if (stat() !== 8'h00) $display("FAIL both_red_init got %b want %b", stat(), 8'h00);
    else n_pass++;
    drive(L_AG, 2);
    drive(L_OFF, 2);
    n_chk++;
    if (stat() !== st(1'b0, 2'd0, 1'b1, 3'd1, 1'b1))
      $display("FAIL all_off_run got %b want %b", stat(), st(1'b0, 2'd0, 1'b1, 3'd1, 1'b1));
    else n_pass++;
    clear_fault("all_off");
  endtask

  task automatic test_startup();
    do_reset();
    drive(L_OFF, 10);
    n_chk++;
    if (stat() !== 8'h00) $display("FAIL startup_idle got %b want %b", stat(), 8'h00);
    else n_pass++;
    drive(L_AG, 2);
    n_chk++;
    if (stat() !== st(1'b1, 2'd0, 1'b0, 3'd0, 1'b0))
      $display("FAIL startup_run got %b want %b", stat(), st(1'b1, 2'd0, 1'b0, 3'd0, 1'b0));
    else n_pass++;
    drive(L_AY, 2);
    n_chk++;
    if (stat() !== st(1'b1, 2'd1, 1'b0, 3'd0, 1'b0))
      $display("FAIL first_phase_waived got %b want %b", stat(), st(1'b1, 2'd1, 1'b0, 3'd0, 1'b0));
    else n_pass++;
    drive(L_GG, 2);
    n_chk++;
    if (stat() !== st(1'b0, 2'd0, 1'b1, 3'd2, 1'b1))
      $display("FAIL startup_fault got %b want %b", stat(), st(1'b0, 2'd0, 1'b1, 3'd2, 1'b1));
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (raw() !== 8'h00) $display("FAIL async_reset got %b want %b", raw(), 8'h00);
    else n_pass++;
    set_lamps(L_OFF);
    step();
    rst_n = 1'b1;
  endtask

`ifdef TL_MON_FAULT_COUNT_EN
  task automatic test_fault_count();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(L_AG, 2);
      drive(L_GG, 2);
      clear_fault("count_cycle");
    end
    n_chk++;
    if (bus.fault_count !== 8'd3)
      $display("FAIL fault_count got %0d want 3", bus.fault_count);
    else n_pass++;
    do_reset();
    n_chk++;
    if (bus.fault_count !== 8'd0)
      $display("FAIL fault_count_reset got %0d want 0", bus.fault_count);
    else n_pass++;
  endtask
`endif

  initial begin
    bus.clr_fault = 1'b0;
    set_lamps(L_OFF);
    test_reset();
    test_normal();
    test_conflict();
    test_short_yellow();
    test_short_green();
    test_illegal();
    test_encoding();
    test_startup();
`ifdef TL_MON_FAULT_COUNT_EN
    test_fault_count();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tl_conflict_monitor.md
Name: tl_conflict_monitor

Overview:
- Independent safety monitor on the lamp side of the two-road intersection controller.
- Samples the six lamp drive lines (Ga/Ya/Ra, Gb/Yb/Rb) and decodes the displayed phase.
- Checks lamp encoding, conflicts, phase order and minimum dwell times.
- On any violation it latches a coded fault and drives an all-red flash request until cleared.

Parameters:
- MIN_GREEN, 4, minimum cycles a green phase must be displayed before leaving it
- MIN_YELLOW, 2, minimum cycles a yellow phase must be displayed before leaving it
- FLASH_DIV, 8, half-period of the flash output, in clk cycles
- CNT_W, 8, width of the dwell and flash counters; counters saturate at 2^CNT_W-1

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- Ga, Ya, Ra  in  1 each  road A lamp drives (green, yellow, red)
- Gb, Yb, Rb  in  1 each  road B lamp drives (green, yellow, red)
- clr_fault  in  1  synchronous fault clear; acts only in FAULT state
- phase  out  2  decoded phase: 0=AG, 1=AY, 2=BG, 3=BY
- phase_valid  out  1  high while in RUN state
- fault  out  1  latched fault flag
- fault_code  out  3  0=none, 1=bad encoding, 2=conflict, 3=illegal transition, 4=yellow short, 5=green short
- flash  out  1  all-red flash request; toggles while faulted

Behaviour:
- Reset state: all outputs 0, FSM in INIT, dwell counter 0, input sample register 0.
- Input stage:
  - The six lamps are registered once into s_lamps; all checks use s_lamps.
  - A pattern presented before edge k is checked at edge k+1, so fault/code/flash update on the second rising edge after the pattern appears.
- Encoding:
  - A direction is valid when exactly one of its three lamps is high.
  - Phase is legal only as AG (Ga,Rb), AY (Ya,Rb), BG (Ra,Gb) or BY (Ra,Yb).
  - Both directions red is treated as encoding fault 1.
- Conflict: any cycle where neither direction shows red, with at least one lamp on each side, gives code 2.
- Code priority when several checks fail in one cycle: 2 > 1 > 3 > 4 > 5.
- FSM INIT:
  - All-zero lamps are ignored, to tolerate controller start-up.
  - Conflict faults immediately.
  - Other invalid encodings are ignored.
  - The first legal phase moves to RUN with dwell=1; the min-dwell check is waived for this first phase.
- FSM RUN:
  - Same phase: dwell increments (saturating).
  - Legal successor (AG->AY, AY->BG, BG->BY, BY->AG): check dwell of the phase being left.
    - Leaving a yellow with dwell < MIN_YELLOW gives code 4.
    - Leaving a green with dwell < MIN_GREEN gives code 5.
    - Otherwise load the new phase and reset dwell to 1.
  - Any other legal phase (skip or reverse) gives code 3.
  - Bad encoding, including all-zero, gives code 1.
- FSM FAULT:
  - fault=1 and fault_code are held at the first fault's code; later violations are ignored.
  - phase_valid=0.
  - flash=1 on the entry cycle, then toggles every FLASH_DIV cycles.
  - clr_fault=1 returns to INIT on the next edge and clears fault, fault_code, flash and dwell in that same edge.
- clr_fault outside FAULT: no effect.
- Fault detected in the same cycle clr_fault is asserted: clear wins; the fault is re-detected later from INIT if the lamps are still bad.
- rst_n low mid-operation: immediate return to the reset state; any latched fault is lost.

Optional Feature:
- Macro TL_MON_FAULT_COUNT_EN.
- Defined: adds output fault_count (8 bits), reset 0, incremented on each entry to FAULT and saturating at 255. clr_fault does not clear it; only rst_n does.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Shared package tl_pkg holds:
  - phase enum (PH_AG, PH_AY, PH_BG, PH_BY)
  - monitor state enum (M_INIT, M_RUN, M_FAULT)
  - fault code constants
  - function next_phase(phase) giving the legal successor
- One natural sub-module: tl_lamp_decode, combinational decode of 6 lamps to {phase, legal, conflict, all_off}, reusable by other lamp-side blocks.

Test Plan:
- Normal cycle: drive AG 5 cycles, AY 2, BG 4, BY 2, repeat 3 times -> fault stays 0, phase_valid=1 from 2nd edge after first AG, phase tracks 0,1,2,3 with 1-cycle lag.
- Conflict: in RUN drive Ga=1,Gb=1 with Ra=Rb=0 -> fault=1, fault_code=2 two edges later, flash=1 then toggling every 8 cycles.
- Short yellow: AG 5 cycles, AY 1 cycle, then BG -> fault_code=4; short green: AG 3 cycles then AY (not first phase) -> fault_code=5.
- Illegal transition: AG 5 cycles directly to BG -> fault_code=3; a later conflict does not change the code; clr_fault pulse -> all outputs 0, INIT, recovers on next AG.
- Start-up: lamps all-zero for 10 cycles after rst_n release, then AG -> no fault, RUN entered; asserting rst_n low while in FAULT -> outputs 0 immediately.
- With TL_MON_FAULT_COUNT_EN: three fault/clear cycles -> fault_count=3; after rst_n -> 0.
